bcd_to_bin: RTL

- Iterative, multi-cycle decoder that converts a packed BCD nonce back to plain binary.
- Pairs with the BCD nonce counter: takes a 15-digit BCD value reported by a hashing core (e.g. a winning nonce) and produces its binary equivalent for the host / result logic.
- Processes one digit per clock, most significant digit first, using acc = acc*10 + digit.
- Valid/ready handshake on both sides.

---
 rtl/bcd_to_bin.sv | 88 ++++++++
 1 files changed

// File: rtl/bcd_to_bin.sv
// Multi-cycle packed-BCD to binary decoder: one digit per clock, MSD first,
// acc = acc*10 + digit, with valid/ready handshakes on input and result.
module bcd_to_bin #(
    parameter int DIGITS    = 15,
    parameter int BIN_WIDTH = 50
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [DIGITS*4-1:0]    rx_bcd,
    input  logic                   rx_valid,
    output logic                   tx_ready,
    output logic [BIN_WIDTH-1:0]   tx_bin,
    output logic                   tx_error,
    output logic                   tx_valid,
    input  logic                   rx_ready
);

    localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t                 state;
    logic [BIN_WIDTH-1:0]   acc;
    logic [DIGITS*4-1:0]    sreg;
    logic [CW-1:0]          cnt;
    logic                   err;

    logic [3:0]             dig;
    logic [BIN_WIDTH-1:0]   acc_nxt;
    logic                   err_nxt;

    // Multiply by ten as two shifts; wraps modulo 2^BIN_WIDTH for bad digits.
    assign dig     = sreg[DIGITS*4-1 -: 4];
    assign acc_nxt = (acc << 3) + (acc << 1) + BIN_WIDTH'(dig);
    assign err_nxt = err | (dig > 4'd9);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            acc      <= '0;
            sreg     <= '0;
            cnt      <= '0;
            err      <= 1'b0;
            tx_bin   <= '0;
            tx_error <= 1'b0;
            tx_valid <= 1'b0;
            tx_ready <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (rx_valid) begin
                        sreg     <= rx_bcd;
                        acc      <= '0;
                        err      <= 1'b0;
                        cnt      <= '0;
                        tx_ready <= 1'b0;
                        state    <= CONV;
                    end
                end
                CONV: begin
                    acc  <= acc_nxt;
                    err  <= err_nxt;
                    sreg <= sreg << 4;
                    cnt  <= cnt + 1'b1;
                    if (cnt == CW'(DIGITS - 1)) begin
                        tx_bin   <= acc_nxt;
                        tx_error <= err_nxt;
                        tx_valid <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    if (rx_ready) begin
                        tx_valid <= 1'b0;
                        tx_ready <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: begin
                    tx_valid <= 1'b0;
                    tx_ready <= 1'b1;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule
